// File: rtl/imem_loader.sv
// imem_loader: takes a framed byte stream from the UART receiver and writes
// big-endian 32-bit words into the instruction BRAM write port.
// Frame: base word address (4 B), word count N (2 B), N*4 payload bytes,
// 1 checksum byte (mod-256 sum of the payload).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           pulse that arms the loader from IDLE or DONE
//   rx_data/valid   incoming byte and its valid flag
//   rx_ready        byte accepted when rx_valid && rx_ready
//   imem_addr/din/we  single-word instruction memory write port
//   busy, done, err   status (done/err sticky until the next start)
module imem_loader #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              imem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BC_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       word_q;
  logic [BC_W-1:0]   bcnt_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic [7:0]        sum_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic              we_q, rx_ready_q, busy_q, done_q, err_q;

  logic              acc;
  logic [31:0]       shift_w;
  logic [CNT_W-1:0]  cnt_w;

  assign acc     = rx_valid && rx_ready_q;
  assign shift_w = {word_q, rx_data};
  assign cnt_w   = CNT_W'({word_q[7:0], rx_data});

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_ADDR;
      S_ADDR:  if (acc && bcnt_q == BC_W'(3)) state_d = S_CNT;
      S_CNT:   if (acc && bcnt_q == BC_W'(1))
                 state_d = (cnt_w == '0) ? S_CSUM : S_DATA;
      S_DATA:  if (acc && bcnt_q == BC_W'(3)) state_d = S_WRITE;
      S_WRITE: state_d = (wcnt_q == CNT_W'(1)) ? S_CSUM : S_DATA;
      S_CSUM:  if (acc) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= state_d inside {S_ADDR, S_CNT, S_DATA, S_CSUM};
      busy_q     <= !(state_d inside {S_IDLE, S_DONE});
      // Strobe lands in the WRITE cycle, right after the 4th word byte
      we_q       <= (state_q == S_DATA) && (state_d == S_WRITE);
      unique case (state_q)
        S_IDLE, S_DONE: if (start) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          sum_q  <= '0;
          bcnt_q <= '0;
          wcnt_q <= '0;
        end
        S_ADDR: if (acc) begin
          word_q <= shift_w[23:0];
          bcnt_q <= bcnt_q + BC_W'(1);
          // Upper address bits beyond ADDR_W are dropped here
          if (bcnt_q == BC_W'(3)) addr_q <= ADDR_W'(shift_w);
        end
        S_CNT: if (acc) begin
          word_q <= shift_w[23:0];
          if (bcnt_q == BC_W'(1)) begin
            bcnt_q <= '0;
            wcnt_q <= cnt_w;
          end else begin
            bcnt_q <= bcnt_q + BC_W'(1);
          end
        end
        S_DATA: if (acc) begin
          word_q <= shift_w[23:0];
          sum_q  <= sum_q + rx_data;
          bcnt_q <= bcnt_q + BC_W'(1);
          if (bcnt_q == BC_W'(3)) din_q <= shift_w;
        end
        S_WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          wcnt_q <= wcnt_q - CNT_W'(1);
        end
        S_CSUM: if (acc) begin
          done_q <= 1'b1;
          err_q  <= (rx_data != sum_q);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign imem_addr = addr_q;
  assign imem_din  = din_q;
  assign imem_we   = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction ROMs used by the MIPS150 test programs. It accepts a framed byte stream from the UART receiver through a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through a single-word write port into the instruction BRAM, so a test program can be loaded at runtime instead of being synthesized into a ROM. It sits between the UART receiver and the instruction memory's write port, and reports completion and checksum status to the CPU or a debug LED.

## Interface
- ADDR_W, 30, width of the word address (instruction memory is word-addressed, `addr[29:0]`)
- CNT_W, 16, width of the word-count field and counter
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that arms the loader; ignored unless state is IDLE or DONE
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle; a byte is consumed when rx_valid && rx_ready
- imem_addr  out  ADDR_W  word address for the write
- imem_din  out  32  write data
- imem_we  out  1  write strobe, one cycle per word
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  sticky; frame complete
- err  out  1  sticky; checksum mismatch (valid only when done=1)

## Operation
- Frame, all fields big-endian:
  - base word address: 4 bytes; the upper 32-ADDR_W bits are discarded
  - word count N: 2 bytes
  - payload: N×4 bytes
  - checksum: 1 byte equal to the mod-256 sum of all payload bytes
- States and transitions:
  - IDLE: on start, go to ADDR.
  - ADDR: after 4 bytes, go to CNT.
  - CNT: after 2 bytes, go to DATA if N≠0, or to CSUM if N=0.
  - DATA: after the 4th byte of a word, go to WRITE.
  - WRITE: issue one write, then go to DATA if words remain, or to CSUM if none remain.
  - CSUM: after 1 byte, go to DONE.
  - DONE: on start, go to ADDR.
- rx_ready is 1 in ADDR, CNT, DATA and CSUM. It is 0 in IDLE, WRITE and DONE.
- Byte assembly: the shift register updates as `{word[23:0], rx_data}`. A 2-bit byte counter wraps 3→0.
- Write address:
  - The first write goes to the base address.
  - Each WRITE increments the address by 1, modulo 2^ADDR_W; 2^ADDR_W−1 wraps to 0.
- The running 8-bit sum covers payload bytes only. It clears when a frame starts.
- Checksum result:
  - In CSUM, err is set when the received byte ≠ the running sum.
  - Writes already issued are never rolled back.
- Leaving DONE or IDLE on start clears done, err, the sum, the byte counter and the word counter.
- start while busy has no effect.
- There is no timeout. A stalled stream holds the current state indefinitely.

## Timing
- Reset values: state=IDLE; rx_ready, imem_we, busy, done and err are 0; imem_addr and imem_din are 0.
- rst has priority over every other input on the same edge. Reset mid-frame:
  - No further writes are issued.
  - A write pending in WRITE is dropped.
  - The next frame needs a new start.
- busy rises in the cycle after start is sampled. rx_ready rises together with it.
- All outputs are registered.
- imem_we:
  - It is high for exactly one cycle: the cycle after the 4th byte of a word is accepted.
  - imem_addr and imem_din are stable during that cycle.
  - imem_we is 0 in every other state.
- Throughput:
  - 1 byte per cycle while rx_valid is held high.
  - Each word costs 5 cycles (4 accept cycles plus 1 WRITE bubble).
- done and err assert in the cycle after the checksum byte is accepted. busy drops in the same cycle.
- rx_valid with rx_ready=0 does not consume the byte. The source must hold the byte.

## Test plan
- Basic load:
  - Stimulus: start, then bytes 00 00 00 10, 00 02, 24 17 00 00, 3C 16 80 00, 0D, with rx_valid held high.
  - Required response: writes (0x10, 0x24170000) and (0x11, 0x3C168000), one cycle apart by 5 cycles; done=1, err=0, busy=0.
- Bad checksum:
  - Stimulus: the same frame with checksum 0E.
  - Required response: both writes occur; done=1, err=1.
- Zero count:
  - Stimulus: address 00 00 00 40, count 00 00, checksum 00.
  - Required response: no imem_we pulses; done=1 in the cycle after the 7th byte.
- Address wrap and masking:
  - Stimulus: address FF FF FF FF (ADDR_W=30), count 2, with valid payload.
  - Required response: writes to 0x3FFFFFFF, then 0x00000000.
- Backpressure and gaps:
  - Stimulus: toggle rx_valid randomly; assert start mid-frame; hold rx_valid high during WRITE.
  - Required response: the same writes as the basic load; start is ignored; no byte is lost or duplicated across the WRITE cycle.
- Reset mid-payload:
  - Stimulus: rst one cycle after the 2nd payload byte.
  - Required response: all outputs return to 0 on the next cycle and no write occurs; a following start with a full frame loads correctly.
